// File: rtl/release_index.sv
// release_index: releases a placed program's width from a strip in the occupancy
// register array. A request is decoded, the strip's occupied width is read back,
// the release is checked against it and, if legal, the strip is truncated.
//
// Optional feature: define STRICT_TOP_RELEASE_EN to accept only a release of the
// topmost program in a strip (x + w must equal the occupied width exactly).
//
// Timing, counting the accepting clock edge as edge 0:
//   edge 1: leave DECODE (strip resolved, early errors go to DONE)
//   edge 3: leave CHECK  (occupied width sampled)
//   edge 4: leave WRITE  (wr_en visible for the following cycle)
//   edge 5: leave DONE   (done visible for the following cycle)
// An early error shows done after edge 2, a failed check after edge 4.

module release_index #(
    parameter int unsigned MAX_WIDTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] x_in,
    input  logic [7:0] y_in,
    input  logic [7:0] w_in,
    output logic [3:0] rd_strip_ID,
    input  logic [7:0] rd_occupied_width,
    output logic       wr_en,
    output logic [3:0] wr_strip_ID,
    output logic [7:0] wr_width,
    output logic       done,
    output logic [1:0] err_code,
    output logic [3:0] strip_ID_out,
    output logic [7:0] freed_width
);

    localparam logic [8:0] MaxW = 9'(MAX_WIDTH);
    localparam logic [7:0] StrikeX = 8'd128;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrInvalid = 2'd1;
    localparam logic [1:0] ErrRange   = 2'd2;
    localparam logic [1:0] ErrZeroW   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StRead,
        StCheck,
        StWrite,
        StDone
    } state_t;

    state_t     state_q;
    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [7:0] w_q;
    logic [3:0] strip_q;
    logic [1:0] err_q;
    logic [7:0] freed_q;

    logic [3:0] dec_id;
    logic [8:0] end_x;
    logic       check_pass;
    logic [7:0] freed_calc;

    // y origin to strip ID; 0 marks an unknown row (including the strike sentinel)
    always_comb begin
        dec_id = 4'd0;
        unique case (y_q)
            8'd0:    dec_id = 4'd1;
            8'd8:    dec_id = 4'd2;
            8'd16:   dec_id = 4'd3;
            8'd25:   dec_id = 4'd4;
            8'd32:   dec_id = 4'd5;
            8'd42:   dec_id = 4'd6;
            8'd48:   dec_id = 4'd7;
            8'd59:   dec_id = 4'd8;
            8'd64:   dec_id = 4'd9;
            8'd76:   dec_id = 4'd10;
            8'd80:   dec_id = 4'd11;
            8'd96:   dec_id = 4'd12;
            8'd112:  dec_id = 4'd13;
            default: dec_id = 4'd0;
        endcase
    end

    // Release legality against the occupied width read back from the array
    always_comb begin
        end_x = {1'b0, x_q} + {1'b0, w_q};
`ifdef STRICT_TOP_RELEASE_EN
        check_pass = (end_x == {1'b0, rd_occupied_width});
        freed_calc = w_q;
`else
        check_pass = (end_x <= {1'b0, rd_occupied_width});
        freed_calc = rd_occupied_width - x_q;
`endif
    end

    // Ready only while idle and out of reset
    assign req_ready = (state_q == StIdle) && !rst;

    // Sequencer with registered array-port and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            w_q          <= 8'd0;
            strip_q      <= 4'd0;
            err_q        <= ErrNone;
            freed_q      <= 8'd0;
            rd_strip_ID  <= 4'd0;
            wr_en        <= 1'b0;
            wr_strip_ID  <= 4'd0;
            wr_width     <= 8'd0;
            done         <= 1'b0;
            err_code     <= 2'd0;
            strip_ID_out <= 4'd0;
            freed_width  <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        w_q     <= w_in;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    strip_q     <= dec_id;
                    rd_strip_ID <= dec_id;
                    freed_q     <= 8'd0;
                    if (dec_id == 4'd0 || x_q == StrikeX) begin
                        err_q   <= ErrInvalid;
                        state_q <= StDone;
                    end else if (w_q == 8'd0) begin
                        err_q   <= ErrZeroW;
                        state_q <= StDone;
                    end else if (end_x > MaxW) begin
                        err_q   <= ErrRange;
                        state_q <= StDone;
                    end else begin
                        err_q   <= ErrNone;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    // Array answers one cycle after rd_strip_ID
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (check_pass) begin
                        freed_q <= freed_calc;
                        state_q <= StWrite;
                    end else begin
                        err_q   <= ErrRange;
                        state_q <= StDone;
                    end
                end
                StWrite: begin
                    // Strip now occupied from 0 up to the released origin
                    wr_en       <= 1'b1;
                    wr_strip_ID <= strip_q;
                    wr_width    <= x_q;
                    state_q     <= StDone;
                end
                StDone: begin
                    done         <= 1'b1;
                    err_code     <= err_q;
                    strip_ID_out <= strip_q;
                    freed_width  <= (err_q == ErrNone) ? freed_q : 8'd0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_release_index.sv
// Bench for release_index: an occupancy-array model answers the read port and
// applies writes; a reference model predicts each request's outcome and timing
// and one compare process checks the DUT on every falling edge.
// Honours STRICT_TOP_RELEASE_EN the same way as the design.

module tb_release_index;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] x_in = 8'd0;
    logic [7:0] y_in = 8'd0;
    logic [7:0] w_in = 8'd0;
    logic [3:0] rd_strip_ID;
    logic [7:0] rd_occupied_width = 8'd0;
    logic       wr_en;
    logic [3:0] wr_strip_ID;
    logic [7:0] wr_width;
    logic       done;
    logic [1:0] err_code;
    logic [3:0] strip_ID_out;
    logic [7:0] freed_width;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [0:15];

    release_index #(.MAX_WIDTH(128)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .x_in              (x_in),
        .y_in              (y_in),
        .w_in              (w_in),
        .rd_strip_ID       (rd_strip_ID),
        .rd_occupied_width (rd_occupied_width),
        .wr_en             (wr_en),
        .wr_strip_ID       (wr_strip_ID),
        .wr_width          (wr_width),
        .done              (done),
        .err_code          (err_code),
        .strip_ID_out      (strip_ID_out),
        .freed_width       (freed_width)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Occupancy register array: 1-cycle read latency, write on wr_en
    always @(posedge clk) begin
        rd_occupied_width <= mem[rd_strip_ID];
        if (wr_en) mem[wr_strip_ID] <= wr_width;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode_y(input int y);
        int rows[13] = '{0, 8, 16, 25, 32, 42, 48, 59, 64, 76, 80, 96, 112};
        decode_y = 0;
        for (int i = 0; i < 13; i++) if (rows[i] == y) decode_y = i + 1;
    endfunction

    // Reference model state for the transaction in flight
    bit have_txn = 0;
    int t_acc, t_done;
    bit t_write;
    int e_err, e_strip, e_freed, e_wwidth;
    int h_err = 0, h_strip = 0, h_freed = 0;

    always @(negedge clk) begin
        if (rst) begin
            have_txn = 0;
            h_err = 0; h_strip = 0; h_freed = 0;
            check("rst_ready", int'(req_ready), 0);
            check("rst_done", int'(done), 0);
            check("rst_wr_en", int'(wr_en), 0);
            check("rst_outs", int'(err_code) + int'(strip_ID_out) + int'(freed_width), 0);
            check("rst_ports", int'(rd_strip_ID) + int'(wr_strip_ID) + int'(wr_width), 0);
        end else begin
            automatic bit busy = have_txn && (cyc < t_done);
            check("ready", int'(req_ready), busy ? 0 : 1);
            check("done_timing", int'(done), (have_txn && cyc == t_done) ? 1 : 0);
            if (have_txn && cyc == t_done) begin
                h_err = e_err; h_strip = e_strip; h_freed = e_freed;
            end
            check("err_code", int'(err_code), h_err);
            check("strip_ID_out", int'(strip_ID_out), h_strip);
            check("freed_width", int'(freed_width), h_freed);
            check("wr_en_timing", int'(wr_en), (have_txn && t_write && cyc == t_acc + 4) ? 1 : 0);
            if (wr_en) begin
                check("wr_strip_ID", int'(wr_strip_ID), e_strip);
                check("wr_width", int'(wr_width), e_wwidth);
            end
            if (req_valid && req_ready) begin
                automatic int x = int'(x_in);
                automatic int w = int'(w_in);
                automatic int id = decode_y(int'(y_in));
                automatic int occ = (id != 0) ? int'(mem[id]) : 0;
                automatic bit ok;
`ifdef STRICT_TOP_RELEASE_EN
                ok = (x + w == occ);
`else
                ok = (x + w <= occ);
`endif
                have_txn = 1;
                t_acc = cyc + 1;
                t_write = 0;
                e_strip = id;
                e_freed = 0;
                e_wwidth = x;
                if (id == 0 || x == 128) begin
                    e_err = 1; t_done = t_acc + 2;
                end else if (w == 0) begin
                    e_err = 3; t_done = t_acc + 2;
                end else if (x + w > 128) begin
                    e_err = 2; t_done = t_acc + 2;
                end else if (ok) begin
                    e_err = 0; t_done = t_acc + 5; t_write = 1;
`ifdef STRICT_TOP_RELEASE_EN
                    e_freed = w;
`else
                    e_freed = occ - x;
`endif
                end else begin
                    e_err = 2; t_done = t_acc + 4;
                end
            end
        end
    end

    // Write observer for literal checks
    int wr_count = 0;
    always @(negedge clk) if (!rst && wr_en) wr_count++;

    int acc_cyc, done_cyc, got_err, got_strip, got_freed;

    task automatic do_req(input int x, input int y, input int w, input bit noise);
        int n;
        @(posedge clk); #1;
        x_in = 8'(x); y_in = 8'(y); w_in = 8'(w); req_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 10) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        acc_cyc = cyc + 1;
        @(posedge clk); #1;
        if (noise) begin
            // Requests while busy must be ignored
            x_in = 8'd3; y_in = 8'd0; w_in = 8'd1;
            repeat (2) @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        n = 0;
        done_cyc = -1;
        while (n < 20) begin
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                got_err = int'(err_code);
                got_strip = int'(strip_ID_out);
                got_freed = int'(freed_width);
                break;
            end
            n++;
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        int wc;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        mem[4] = 8'd16; mem[5] = 8'd10; mem[7] = 8'd30; mem[12] = 8'd128; mem[13] = 8'd16;

        repeat (3) @(negedge clk);
        check("lit_reset_ready", int'(req_ready), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("lit_ready_after_rst", int'(req_ready), 1);

        // Normal release
        wc = wr_count;
        do_req(10, 25, 6, 1'b0);
        check("lit_031_latency", done_cyc - acc_cyc, 5);
        check("lit_031_err", got_err, 0);
        check("lit_031_strip", got_strip, 4);
        check("lit_031_freed", got_freed, 6);
        check("lit_031_mem", int'(mem[4]), 10);
        check("lit_031_writes", wr_count - wc, 1);

        // Strike sentinel
        wc = wr_count;
        do_req(128, 128, 5, 1'b0);
        check("lit_032_latency", done_cyc - acc_cyc, 2);
        check("lit_032_err", got_err, 1);
        check("lit_032_writes", wr_count - wc, 0);

        do_req(3, 20, 4, 1'b0);
        check("lit_033_err", got_err, 1);
        check("lit_033_strip", got_strip, 0);
        do_req(3, 8, 0, 1'b0);
        check("lit_033_zero_w", got_err, 3);
        check("lit_033_zero_w_strip", got_strip, 2);

        do_req(128, 8, 4, 1'b0);
        check("lit_x_strike_err", got_err, 1);

        // Below the top of strip 13
        do_req(4, 112, 6, 1'b0);
`ifdef STRICT_TOP_RELEASE_EN
        check("lit_034_err", got_err, 2);
        check("lit_034_mem", int'(mem[13]), 16);
`else
        check("lit_034_err", got_err, 0);
        check("lit_034_freed", got_freed, 12);
        check("lit_034_mem", int'(mem[13]), 4);
`endif

        // Out of strip range, rejected before reading
        do_req(120, 0, 20, 1'b0);
        check("lit_035_err", got_err, 2);
        check("lit_035_latency", done_cyc - acc_cyc, 2);
        do_req(255, 0, 255, 1'b0);
        check("lit_no_wrap_err", got_err, 2);

        // Exact full strip; noise while busy
        do_req(100, 96, 28, 1'b1);
        check("lit_full_err", got_err, 0);
        check("lit_full_freed", got_freed, 28);
        check("lit_full_mem", int'(mem[12]), 100);

        // Failing read-based check (end 13 beyond occupied 10)
        do_req(8, 32, 5, 1'b0);
        check("lit_chk_err", got_err, 2);
        check("lit_chk_latency", done_cyc - acc_cyc, 4);

        // Reset during WRITE aborts the write
        wc = wr_count;
        @(posedge clk); #1;
        x_in = 8'd10; y_in = 8'd48; w_in = 8'd20; req_valid = 1'b1;
        @(negedge clk);
        check("lit_rst_accept", int'(req_ready), 1);
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("lit_036_writes", wr_count - wc, 0);
        check("lit_036_mem", int'(mem[7]), 30);
        do_req(20, 48, 10, 1'b0);
        check("lit_036_next_err", got_err, 0);
        check("lit_036_next_freed", got_freed, 10);
        check("lit_036_next_mem", int'(mem[7]), 20);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
